// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
// Shared types and default constants for the pushbutton accumulator.
//   accum_state_t   : button-tracking FSM states
//   ACCUM_WIDTH_DEF : default accumulator / addend width
//   SYNC_STAGES_DEF : default number of button synchroniser flops
// -----------------------------------------------------------------------------
package accum_pkg;

  localparam int unsigned ACCUM_WIDTH_DEF = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ARM_WAIT = 2'd0,
    IDLE     = 2'd1,
    HELD     = 2'd2
  } accum_state_t;

  // Saturating counter step used to track synchroniser priming after reset.
  function automatic logic [2:0] sat_inc3(input logic [2:0] cnt, input logic [2:0] limit);
    return (cnt == limit) ? cnt : (cnt + 3'd1);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
// Multi-flop synchroniser bringing the raw pushbutton into the clk domain.
// Ports:
//   clk   : sampling clock
//   reset : asynchronous active-low reset, clears every stage to 0
//   d     : raw asynchronous input
//   q     : output of the last synchroniser stage
// -----------------------------------------------------------------------------
module btn_sync
  import accum_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/accum_reg.sv
// -----------------------------------------------------------------------------
// accum_reg
// Pushbutton-driven accumulator: every accepted press adds `addend` to the
// registered accumulator once, with a sticky overflow flag and a one-cycle
// strobe after each committed accumulation.
// Ports:
//   clk        : single clock, rising edge
//   reset      : asynchronous active-low reset
//   btn        : raw pushbutton, asynchronous, active-high
//   clear      : synchronous clear of accumulator and carry (FSM untouched)
//   addend     : value added on each accepted press
//   data_out   : registered accumulator value
//   carry      : sticky overflow flag
//   step_pulse : registered strobe, high the cycle after each commit
// Configuration macro:
//   ACCUM_SAT_EN : when defined, an overflowing commit clamps to all ones;
//                  otherwise it wraps modulo 2^WIDTH. carry is set either way.
// -----------------------------------------------------------------------------
module accum_reg
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH       = ACCUM_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             clear,
  input  logic [WIDTH-1:0] addend,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             step_pulse
);

  // The synchroniser output is only meaningful once SYNC_STAGES edges have
  // shifted real button samples through it; its reset zeros must not be read
  // as "button released", or a button held through reset would be accepted.
  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

  logic                 s;
  accum_state_t         state_q;
  logic [2:0]           prime_q;
  logic                 prime_done;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     acc_d;
  logic                 carry_q;
  logic                 step_q;
  logic [WIDTH:0]       sum_full;
  logic                 overflow;
  logic                 commit;

  btn_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (s)
  );

  assign prime_done = (prime_q == PRIME_LAST);
  assign sum_full   = {1'b0, acc_q} + {1'b0, addend};
  assign overflow   = sum_full[WIDTH];
  assign commit     = (state_q == IDLE) && s;

`ifdef ACCUM_SAT_EN
  assign acc_d = overflow ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
  assign acc_d = sum_full[WIDTH-1:0];
`endif

  // Button FSM plus accumulator datapath; clear overrides a same-edge commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARM_WAIT;
      prime_q <= 3'd0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      prime_q <= sat_inc3(prime_q, PRIME_LAST);
      step_q  <= 1'b0;

      case (state_q)
        ARM_WAIT: begin
          if (prime_done && !s) begin
            state_q <= IDLE;
          end else begin
            state_q <= ARM_WAIT;
          end
        end
        IDLE: begin
          if (s) begin
            state_q <= HELD;
          end else begin
            state_q <= IDLE;
          end
        end
        HELD: begin
          if (!s) begin
            state_q <= IDLE;
          end else begin
            state_q <= HELD;
          end
        end
        default: begin
          state_q <= ARM_WAIT;
        end
      endcase

      if (clear) begin
        acc_q   <= '0;
        carry_q <= 1'b0;
      end else if (commit) begin
        acc_q   <= acc_d;
        carry_q <= carry_q | overflow;
        step_q  <= 1'b1;
      end else begin
        acc_q   <= acc_q;
        carry_q <= carry_q;
      end
    end
  end

  assign data_out   = acc_q;
  assign carry      = carry_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_accum_reg.sv
// -----------------------------------------------------------------------------
// tb_accum_reg
// Self-checking bench for accum_reg (WIDTH=4, SYNC_STAGES=2). A behavioural
// model treats the button as "the value seen SYNC_STAGES edges ago" and
// accepts a press whenever that delayed value is 1 after having been 0.
// Honours ACCUM_SAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_accum_reg;
  import accum_pkg::*;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int MODV = 1 << W;

  logic         clk;
  logic         reset;
  logic         btn;
  logic         clear;
  logic [W-1:0] addend;
  logic [W-1:0] data_out;
  logic         carry;
  logic         step_pulse;

  int n_cmp;
  int n_err;
  int pulse_cnt;

  // reference model state
  int m_dly[$];
  bit m_ready;
  int m_acc;
  bit m_carry;
  bit m_pulse;

  accum_reg #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .clear      (clear),
    .addend     (addend),
    .data_out   (data_out),
    .carry      (carry),
    .step_pulse (step_pulse)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dly = {};
    for (int i = 0; i < SYNC; i++) m_dly.push_back(-1);
    m_ready = 1'b0;
    m_acc   = 0;
    m_carry = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_step();
    int  s;
    int  sum;
    bit  accept;
    s = m_dly.pop_front();
    m_dly.push_back(int'(btn));
    accept  = m_ready && (s == 1);
    m_ready = (s == 0);
    m_pulse = 1'b0;
    if (clear) begin
      m_acc   = 0;
      m_carry = 1'b0;
    end else if (accept) begin
      sum = m_acc + int'(addend);
      if (sum >= MODV) m_carry = 1'b1;
`ifdef ACCUM_SAT_EN
      m_acc = (sum >= MODV) ? MODV - 1 : sum;
`else
      m_acc = sum % MODV;
`endif
      m_pulse = 1'b1;
    end
  endtask

  task automatic compare_outputs(input string where);
    check_eq({where, ".data_out"},   32'(data_out),   32'(m_acc));
    check_eq({where, ".carry"},      32'(carry),      32'(m_carry));
    check_eq({where, ".step_pulse"}, 32'(step_pulse), 32'(m_pulse));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    compare_outputs("cyc");
    if (step_pulse === 1'b1) pulse_cnt++;
  endtask

  // asynchronous reset assertion between clock edges, checked before any edge
  task automatic assert_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    compare_outputs(tag);
    check_eq({tag, ".state"}, 32'(dut.state_q), 32'(ARM_WAIT));
    tick();
    reset = 1'b1;
  endtask

  task automatic press(input int hold);
    btn = 1'b1;
    repeat (hold) tick();
    btn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin : stim
    int first_chg;
    int pc0;
    logic [W-1:0] base;
    logic [W-1:0] exp_v;
    bit nb;

    n_cmp = 0; n_err = 0; pulse_cnt = 0;
    btn = 1'b1; clear = 1'b0; addend = 4'd3; reset = 1'b1;
    model_reset();
    #2;

    // button held through reset release: no accumulation
    assert_reset("rst0");
    pc0 = pulse_cnt;
    repeat (20) tick();
    check_eq("held_rst.data", 32'(data_out), 32'd0);
    check_eq("held_rst.pulses", 32'(pulse_cnt - pc0), 32'd0);
    btn = 1'b0;
    repeat (4) tick();
    press(5);
    check_eq("held_rst.after_press", 32'(data_out), 32'd3);

    // three clean presses with addend 3
    do_clear();
    addend = 4'd3;
    pc0 = pulse_cnt;
    press(5); check_eq("p3.first",  32'(data_out), 32'd3);
    press(6); check_eq("p3.second", 32'(data_out), 32'd6);
    press(4); check_eq("p3.third",  32'(data_out), 32'd9);
    check_eq("p3.pulses", 32'(pulse_cnt - pc0), 32'd3);
    check_eq("p3.carry",  32'(carry), 32'd0);

    // overflow from 14 + 5, then +1 with carry sticky
    do_clear();
    addend = 4'd14; press(5);
    check_eq("ovf.preload", 32'(data_out), 32'd14);
    addend = 4'd5;  press(5);
`ifdef ACCUM_SAT_EN
    exp_v = 4'd15;
`else
    exp_v = 4'd3;
`endif
    check_eq("ovf.data",  32'(data_out), 32'(exp_v));
    check_eq("ovf.carry", 32'(carry), 32'd1);
    addend = 4'd1;  press(5);
    check_eq("ovf.sticky", 32'(carry), 32'd1);

    // long hold: one commit, data changes on 3rd edge
    do_clear();
    addend = 4'd1;
    repeat (3) tick();
    base = data_out;
    first_chg = 0;
    pc0 = pulse_cnt;
    btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (first_chg == 0 && data_out != base) first_chg = i;
    end
    btn = 1'b0;
    repeat (4) tick();
    check_eq("hold.latency", 32'(first_chg), 32'd3);
    check_eq("hold.pulses",  32'(pulse_cnt - pc0), 32'd1);
    check_eq("hold.data",    32'(data_out), 32'd1);

    // clear coincident with commit: commit discarded
    addend = 4'd9;
    pc0 = pulse_cnt;
    btn = 1'b1;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clrcommit.data",  32'(data_out), 32'd0);
    check_eq("clrcommit.carry", 32'(carry), 32'd0);
    check_eq("clrcommit.pulse", 32'(step_pulse), 32'd0);
    check_eq("clrcommit.state", 32'(dut.state_q), 32'(HELD));
    repeat (5) tick();
    check_eq("clrcommit.nodefer", 32'(pulse_cnt - pc0), 32'd0);
    btn = 1'b0;
    repeat (4) tick();
    addend = 4'd2;
    press(5);
    check_eq("clrcommit.next", 32'(data_out), 32'd2);

    // reset while held with data_out = 7
    do_clear();
    addend = 4'd7;
    btn = 1'b1;
    repeat (5) tick();
    check_eq("midrst.pre", 32'(data_out), 32'd7);
    assert_reset("midrst");
    repeat (10) tick();
    check_eq("midrst.held_after", 32'(data_out), 32'd0);
    btn = 1'b0;
    repeat (4) tick();

    // randomized phase: random button runs with sub-cycle glitches
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) nb = ~btn;
      else nb = btn;
      if ($urandom_range(0, 4) == 0) begin
        btn = ~nb;
        #2;
      end
      btn    = nb;
      addend = 4'($urandom_range(0, 15));
      clear  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 299) == 0) begin
        clear = 1'b0;
        assert_reset("rnd_rst");
      end else begin
        tick();
      end
    end
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global guard so the run always ends
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
